// File: rtl/wb_capture_fifo.sv
// Writeback capture FIFO: queues qualified WB words, drains over valid/ready,
// counts overflow drops and optionally halts capture on the first drop.
module wb_capture_fifo #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int HALT_ON_OVF = 1,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     cap_en,
    input  logic                     wb_valid,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     ovf,
    output logic [1:0]               state
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] HALT = 2'b10;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic              run, full, pop, push, drop;

    assign run       = (state == RUN);
    assign full      = (level == FULL_LVL);
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign push      = wb_valid && run && (!full || pop);
    assign drop      = wb_valid && run && full && !pop;
    assign rd_nxt    = rd_ptr + ADDR_W'(1);

    // Storage carries no reset; validity is tracked entirely by level.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wb_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            out_data <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
            state    <= IDLE;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            out_data <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
            state    <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_nxt;

            case ({push, pop})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase

            // Output register tracks the head entry after this edge; when the
            // FIFO is (or becomes) a single entry, the new head is the incoming word.
            if (pop && level != ONE_LVL)
                out_data <= mem[rd_nxt];
            else if (push && (level == '0 || pop))
                out_data <= wb_data;

            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            end

            case (state)
                IDLE:    if (cap_en) state <= RUN;
                RUN: begin
                    if (drop && HALT_ON_OVF != 0) state <= HALT;
                    else if (!cap_en)             state <= IDLE;
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_capture_fifo.sv
// Directed bench for wb_capture_fifo: one instance per overflow policy,
// driven from shared inputs.
module tb_wb_capture_fifo;
    logic        clk = 1'b0;
    logic        reset, clr, cap_en, wb_valid, out_ready;
    logic [31:0] wb_data;

    logic        ov0, ov1, of0, of1;
    logic [31:0] od0, od1;
    logic [3:0]  lv0, lv1;
    logic [15:0] dc0, dc1;
    logic [1:0]  st0, st1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_capture_fifo #(.DATA_W(32), .DEPTH(8), .HALT_ON_OVF(0), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .clr(clr), .cap_en(cap_en), .wb_valid(wb_valid),
        .wb_data(wb_data), .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
        .level(lv0), .drop_cnt(dc0), .ovf(of0), .state(st0));

    wb_capture_fifo #(.DATA_W(32), .DEPTH(8), .HALT_ON_OVF(1), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .clr(clr), .cap_en(cap_en), .wb_valid(wb_valid),
        .wb_data(wb_data), .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
        .level(lv1), .drop_cnt(dc1), .ovf(of1), .state(st1));

    typedef struct {
        logic        wbv;
        logic [31:0] d;
        logic        rdy;
        logic [3:0]  lvl;
        logic        ov;
        logic        chkd;
        logic [31:0] od;
    } vec_t;

    vec_t tv[6];
    logic [31:0] q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the active edge; outputs sampled at that point too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0] = '{1'b1, 32'h11, 1'b0, 4'd1, 1'b1, 1'b1, 32'h11};
        tv[1] = '{1'b1, 32'h22, 1'b0, 4'd2, 1'b1, 1'b1, 32'h11};
        tv[2] = '{1'b1, 32'h33, 1'b0, 4'd3, 1'b1, 1'b1, 32'h11};
        tv[3] = '{1'b0, 32'h0,  1'b1, 4'd2, 1'b1, 1'b1, 32'h22};
        tv[4] = '{1'b0, 32'h0,  1'b1, 4'd1, 1'b1, 1'b1, 32'h33};
        tv[5] = '{1'b0, 32'h0,  1'b1, 4'd0, 1'b0, 1'b0, 32'h0};

        // Reset held with capture requested.
        reset = 1'b0; clr = 1'b0; cap_en = 1'b1; wb_valid = 1'b1;
        wb_data = 32'h55; out_ready = 1'b0;
        step(); step();
        check("rst_state0", st0, 2'b00);   check("rst_state1", st1, 2'b00);
        check("rst_level", lv0, 0);        check("rst_valid", ov0, 0);
        check("rst_data", od0, 0);         check("rst_drop", dc0, 0);
        check("rst_ovf", of0, 0);
        wb_valid = 1'b0;
        reset = 1'b1;
        step();
        check("run_after_rel0", st0, 2'b01);
        check("run_after_rel1", st1, 2'b01);

        // In-order push then drain.
        for (int i = 0; i < 6; i++) begin
            wb_valid = tv[i].wbv; wb_data = tv[i].d; out_ready = tv[i].rdy;
            step();
            check($sformatf("tv%0d_level", i), lv0, tv[i].lvl);
            check($sformatf("tv%0d_valid", i), ov0, tv[i].ov);
            if (tv[i].chkd) check($sformatf("tv%0d_data", i), od0, tv[i].od);
        end
        out_ready = 1'b0;

        // Overflow: 10 words into 8 entries.
        for (int i = 0; i < 10; i++) begin
            wb_valid = 1'b1; wb_data = 32'h100 + i;
            step();
        end
        wb_valid = 1'b0;
        check("ovf_level0", lv0, 8);   check("ovf_drop0", dc0, 2);
        check("ovf_flag0", of0, 1);    check("ovf_state0", st0, 2'b01);
        check("ovf_level1", lv1, 8);   check("ovf_drop1", dc1, 1);
        check("ovf_state1", st1, 2'b10);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_v", i), ov0, 1);
            check($sformatf("drain%0d_d0", i), od0, 32'h100 + i);
            check($sformatf("drain%0d_d1", i), od1, 32'h100 + i);
            step();
        end
        check("drain_level", lv0, 0);  check("drain_valid", ov0, 0);
        out_ready = 1'b0;

        // Halt on first drop, then clear.
        clr = 1'b1;
        step();
        check("clr_state1", st1, 2'b00); check("clr_drop1", dc1, 0);
        check("clr_ovf1", of1, 0);       check("clr_level1", lv1, 0);
        clr = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            wb_valid = 1'b1; wb_data = 32'h200 + i;
            step();
        end
        wb_data = 32'hDEAD;
        step();
        check("halt_drop1", dc1, 1);     check("halt_state1", st1, 2'b10);
        check("halt_drop0", dc0, 1);     check("halt_state0", st0, 2'b01);
        for (int i = 0; i < 3; i++) step();
        check("halt_hold_drop1", dc1, 1); check("nohalt_drop0", dc0, 4);
        check("halt_level1", lv1, 8);
        wb_valid = 1'b0; clr = 1'b1;
        step();
        check("clr2_level", lv1, 0);  check("clr2_drop", dc1, 0);
        check("clr2_ovf", of1, 0);    check("clr2_state", st1, 2'b00);
        check("clr2_drop0", dc0, 0);
        clr = 1'b0;
        step();

        // Full FIFO, simultaneous push and pop across pointer wrap.
        q.delete();
        for (int i = 0; i < 8; i++) begin
            wb_valid = 1'b1; wb_data = 32'h300 + i; q.push_back(wb_data);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap%0d_d0", i), od0, q[0]);
            check($sformatf("wrap%0d_d1", i), od1, q[0]);
            wb_data = 32'h400 + i;
            step();
            void'(q.pop_front());
            q.push_back(32'h400 + i);
            check($sformatf("wrap%0d_lvl", i), lv0, 8);
        end
        check("wrap_drop0", dc0, 0); check("wrap_drop1", dc1, 0);
        check("wrap_state1", st1, 2'b01);

        // Asynchronous reset with data in flight.
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        check("pre_arst_level", lv0, 5);
        #2 reset = 1'b0;
        #1;
        check("arst_level", lv0, 0);   check("arst_valid", ov0, 0);
        check("arst_data", od0, 0);    check("arst_state", st0, 2'b00);
        check("arst_level1", lv1, 0);  check("arst_data1", od1, 0);
        #3 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_arst%0d_v", i), ov0, 0);
            check($sformatf("post_arst%0d_l", i), lv1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
